// File: rtl/key_bounce_gen.sv
// Emulates a mechanical key press: LFSR-driven contact bounce on press and release,
// a stable hold phase and a quiet gap. The gap's final cycle pulses done and bumps press_cnt.
module key_bounce_gen #(
   parameter int unsigned BOUNCE_CYCLES  = 50_000,
   parameter int unsigned CHATTER_CYCLES = 1_000,
   parameter int unsigned GAP_CYCLES     = 250_000,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] hold_len,
   output logic        key_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] press_cnt
);

   localparam int unsigned SUB_W = (CHATTER_CYCLES > 1) ? $clog2(CHATTER_CYCLES) : 1;
   localparam logic [31:0]      BNC_LAST  = 32'(BOUNCE_CYCLES - 1);
   localparam logic [31:0]      GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [SUB_W-1:0] CHAT_LAST = SUB_W'(CHATTER_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PRESS_BNC, HOLD, REL_BNC, GAP} state_t;

   state_t           state, state_nxt;
   logic [31:0]      phase;
   logic [31:0]      hold_q;
   logic [SUB_W-1:0] sub;
   logic [15:0]      lfsr;
   logic             key_nxt;
   logic             accept;
   logic             in_bnc;
   logic             tick;
   logic             lfsr_fb;

   assign busy    = (state != IDLE);
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_comb begin
      state_nxt = state;
      key_nxt   = key_out;
      done      = 1'b0;
      accept    = 1'b0;
      in_bnc    = (state == PRESS_BNC) || (state == REL_BNC);
      // A tick on the last bounce cycle still steps the LFSR; the next state's entry level wins on key_out.
      tick      = in_bnc && (sub == CHAT_LAST) && !abort;
      case (state)
         IDLE: begin
            key_nxt = 1'b0;
            if (start && !abort) begin
               state_nxt = PRESS_BNC;
               key_nxt   = 1'b1;
               accept    = 1'b1;
            end
         end
         PRESS_BNC: begin
            if (tick) key_nxt = lfsr[0];
            if (phase == BNC_LAST) begin
               state_nxt = HOLD;
               key_nxt   = 1'b1;
            end
         end
         HOLD: begin
            key_nxt = 1'b1;
            if (phase == hold_q - 32'd1) begin
               state_nxt = REL_BNC;
               key_nxt   = 1'b0;
            end
         end
         REL_BNC: begin
            if (tick) key_nxt = lfsr[0];
            if (phase == BNC_LAST) begin
               state_nxt = GAP;
               key_nxt   = 1'b0;
            end
         end
         GAP: begin
            key_nxt = 1'b0;
            if (phase == GAP_LAST) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            key_nxt   = 1'b0;
         end
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         key_nxt   = 1'b0;
         done      = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_out   <= 1'b0;
         phase     <= '0;
         sub       <= '0;
         lfsr      <= SEED;
         hold_q    <= '0;
         press_cnt <= '0;
      end else begin
         state   <= state_nxt;
         key_out <= key_nxt;
         if ((state_nxt != state) || (state_nxt == IDLE)) phase <= '0;
         else                                              phase <= phase + 32'd1;
         if ((state_nxt != state) || !in_bnc || tick) sub <= '0;
         else                                         sub <= sub + 1'b1;
         if (accept) hold_q <= (hold_len == 32'd0) ? 32'd1 : hold_len;
         if (tick)   lfsr   <= {lfsr_fb, lfsr[15:1]};
         if (done)   press_cnt <= press_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed/randomised bench for key_bounce_gen: per-cycle waveform model derived from the
// phase lengths and an LFSR bit table, plus a simple downstream debouncer.
module tb_key_bounce_gen;

   localparam int          B    = 20;
   localparam int          C    = 4;
   localparam int          G    = 10;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        sysclk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        abort  = 1'b0;
   logic [31:0] hold_len = '0;
   logic        key_out;
   logic        busy;
   logic        done;
   logic [15:0] press_cnt;

   int checks = 0;
   int errors = 0;
   int cnt_m   = 0;
   int steps_m = 0;
   bit lbits [4096];
   int run = 0;
   int deb_cnt = 0;

   always #5 sysclk = ~sysclk;

   key_bounce_gen #(
      .BOUNCE_CYCLES (B),
      .CHATTER_CYCLES(C),
      .GAP_CYCLES    (G),
      .SEED          (SEED)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .hold_len (hold_len),
      .key_out  (key_out),
      .busy     (busy),
      .done     (done),
      .press_cnt(press_cnt)
   );

   // Downstream debouncer: flag once key_out has been high for 20 consecutive samples.
   always @(posedge sysclk) begin
      if (!key_out)      run <= 0;
      else if (run < 20) run <= run + 1;
      if (key_out && run == 19) deb_cnt <= deb_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounce level at window cycle i: entry level until the first chatter update, then LFSR bits.
   function automatic bit bnc(input int i, input bit init, input int base);
      if (i < C) return init;
      return lbits[base + i / C - 1];
   endfunction

   function automatic bit exp_key(input int t, input int hq, input int s0);
      if (t < B)            return bnc(t, 1'b1, s0);
      if (t < B + hq)       return 1'b1;
      if (t < 2 * B + hq)   return bnc(t - B - hq, 1'b0, s0 + B / C);
      return 1'b0;
   endfunction

   function automatic int ticks_before(input int n, input int hq);
      int cnt = 0;
      for (int j = 0; j < n; j++) begin
         if (j < B && (j % C) == C - 1) cnt++;
         else if (j >= B + hq && j < 2 * B + hq && ((j - B - hq) % C) == C - 1) cnt++;
      end
      return cnt;
   endfunction

   // Issues start in the current cycle and checks every cycle of the press.
   // stop_at < 0: run to completion; otherwise abort (or reset when by_rst) in that cycle.
   task automatic do_press(input int hl, input int stop_at, input bit by_rst, input bit noise);
      int  hq;
      int  total;
      bit  full;
      hq    = (hl == 0) ? 1 : hl;
      total = 2 * B + hq + G;
      full  = (stop_at < 0) || (stop_at >= total);
      hold_len = 32'(hl);
      start = 1'b1;
      abort = 1'b0;
      for (int t = 0; t < total; t++) begin
         @(posedge sysclk); #1;
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) hold_len = $urandom;
         abort = (t == stop_at) && !by_rst;
         rst_n = !((t == stop_at) && by_rst);
         #1;
         chk("busy", 32'(busy), 32'd1);
         chk("key", 32'(key_out), 32'(exp_key(t, hq, steps_m)));
         chk("done", 32'(done), 32'((t == total - 1) && (t != stop_at)));
         chk("press_cnt", 32'(press_cnt), 32'(cnt_m));
         if (t == stop_at) break;
      end
      @(posedge sysclk); #1;
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      if (full) begin
         cnt_m   = (cnt_m + 1) & 16'hFFFF;
         steps_m = steps_m + 2 * (B / C);
      end else if (by_rst) begin
         cnt_m   = 0;
         steps_m = 0;
      end else begin
         steps_m = steps_m + ticks_before(stop_at, hq);
      end
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_key", 32'(key_out), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_cnt", 32'(press_cnt), 32'(cnt_m));
   endtask

   initial begin
      logic [15:0] l;
      int          d0;
      int          hl;
      int          tot;
      l = SEED;
      for (int n = 0; n < 4096; n++) begin
         lbits[n] = l[0];
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      end

      // Reset with start held high: inputs must be ignored.
      rst_n = 1'b0; start = 1'b1; hold_len = 32'd7;
      repeat (3) @(posedge sysclk);
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_key", 32'(key_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(press_cnt), 32'd0);

      // First edge with rst_n high accepts the pending start.
      rst_n = 1'b1;
      do_press(100, -1, 1'b0, 1'b0);
      do_press(0, -1, 1'b0, 1'b0);
      do_press(100, 30, 1'b0, 1'b0);
      do_press(int'($urandom_range(1, 30)), -1, 1'b0, 1'b0);
      do_press(int'($urandom_range(0, 30)), -1, 1'b0, 1'b1);

      // start together with abort in IDLE is ignored.
      start = 1'b1; abort = 1'b1;
      @(posedge sysclk); #1;
      start = 1'b0; abort = 1'b0;
      #1;
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_key", 32'(key_out), 32'd0);
      chk("sa_cnt", 32'(press_cnt), 32'(cnt_m));

      // Abort on the final GAP cycle suppresses done and the count.
      do_press(5, 2 * B + 5 + G - 1, 1'b0, 1'b0);
      // Abort during bounce windows, then continue from the resulting LFSR position.
      do_press(8, 9, 1'b0, 1'b0);
      do_press(8, 2 * B + 8 - 3, 1'b0, 1'b0);
      do_press(12, -1, 1'b0, 1'b0);

      for (int k = 0; k < 3; k++) begin
         hl  = int'($urandom_range(0, 40));
         tot = 2 * B + ((hl == 0) ? 1 : hl) + G;
         do_press(hl, ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, tot - 1)),
                  1'b0, 1'($urandom_range(0, 1)));
      end

      // Reset mid-HOLD clears everything including press_cnt and the LFSR.
      do_press(50, B + 10, 1'b1, 1'b0);

      // Five back-to-back presses through the debouncer.
      d0 = deb_cnt;
      for (int k = 0; k < 5; k++) do_press(200, -1, 1'b0, 1'b0);
      @(posedge sysclk); #2;
      chk("deb_flags", 32'(deb_cnt - d0), 32'd5);
      chk("cnt_after5", 32'(press_cnt), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
